// File: rtl/note_synth_pwm.sv
// note_synth_pwm: one-hot game note -> triangle tone with attack/release
// envelope, delivered to the board PWM audio amplifier.
//
// Ports:
//   clk_in          100 MHz system clock
//   rst_in          synchronous active-high reset
//   enable_in       0 => note_in treated as no note
//   note_in[6:0]    one-hot note request, bit0=C4 .. bit6=B4,
//                   highest set bit wins
//   aud_pwm         registered PWM audio output
//   aud_sd          amplifier enable, high while a note sounds
//   active_out      high while a note sounds
//   env_out[7:0]    current envelope value
//   sample_tick_out one-cycle pulse on every audio sample tick
module note_synth_pwm #(
    parameter int SAMPLE_DIV   = 2048,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 4,
    parameter int PHASE_W      = 24
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [6:0] note_in,
    output logic       aud_pwm,
    output logic       aud_sd,
    output logic       active_out,
    output logic [7:0] env_out,
    output logic       sample_tick_out
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic [7:0]         pwm_cnt;
    logic [7:0]         env;
    logic [7:0]         level;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tw;

    logic               tick;
    logic               note_valid;
    logic [2:0]         note_idx;
    logic [PHASE_W-1:0] note_tw;
    logic [8:0]         env_sum;
    logic [7:0]         env_up;
    logic [7:0]         env_dn;
    logic [7:0]         wave_pos;
    logic [7:0]         fold;
    logic [7:0]         tri_val;
    logic [15:0]        prod;

    // Phase increments for C4..B4 at a 48.828 kHz sample rate.
    function automatic logic [PHASE_W-1:0] tw_lut(input logic [2:0] idx);
        logic [PHASE_W-1:0] r;
        unique case (idx)
            3'd0:    r = PHASE_W'(89895);
            3'd1:    r = PHASE_W'(100901);
            3'd2:    r = PHASE_W'(113260);
            3'd3:    r = PHASE_W'(119994);
            3'd4:    r = PHASE_W'(134690);
            3'd5:    r = PHASE_W'(151183);
            3'd6:    r = PHASE_W'(169696);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign tick = (tick_cnt == CNT_LAST);

    // Later bits overwrite earlier ones, so the highest index wins.
    always_comb begin
        note_valid = 1'b0;
        note_idx   = 3'd0;
        if (enable_in) begin
            for (int i = 0; i < 7; i++) begin
                if (note_in[i]) begin
                    note_valid = 1'b1;
                    note_idx   = 3'(i);
                end
            end
        end
        note_tw = tw_lut(note_idx);
    end

    // Saturating envelope steps.
    always_comb begin
        env_sum = {1'b0, env} + 9'(ATTACK_STEP);
        env_up  = env_sum[8] ? 8'hFF : env_sum[7:0];
        if (env < 8'(RELEASE_STEP)) begin
            env_dn = 8'd0;
        end else begin
            env_dn = env - 8'(RELEASE_STEP);
        end
    end

    // Triangle from the top phase byte, scaled by the envelope.
    always_comb begin
        wave_pos = phase[PHASE_W-1 -: 8];
        fold     = {wave_pos[6:0], 1'b0};
        tri_val  = wave_pos[7] ? (8'd255 - fold) : fold;
        prod     = 16'(tri_val) * 16'(env);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tick_cnt <= '0;
            pwm_cnt  <= 8'd0;
            aud_pwm  <= 1'b0;
            level    <= 8'd0;
            state    <= IDLE;
            env      <= 8'd0;
            phase    <= '0;
            tw       <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            pwm_cnt  <= pwm_cnt + 8'd1;
            level    <= prod[15:8];
            aud_pwm  <= (pwm_cnt < level);
            if (tick) begin
                // Advance with the word in force before any retune.
                if (state != IDLE) begin
                    phase <= phase + tw;
                end
                unique case (state)
                    IDLE: begin
                        if (note_valid) begin
                            state <= ATTACK;
                            phase <= '0;
                            tw    <= note_tw;
                        end
                    end
                    ATTACK: begin
                        if (!note_valid) begin
                            state <= RELEASE;
                        end else begin
                            tw  <= note_tw;
                            env <= env_up;
                            if (env_up == 8'hFF) begin
                                state <= SUSTAIN;
                            end
                        end
                    end
                    SUSTAIN: begin
                        // Release starts decaying on the same tick.
                        if (!note_valid) begin
                            state <= RELEASE;
                            env   <= env_dn;
                        end else begin
                            tw <= note_tw;
                        end
                    end
                    RELEASE: begin
                        if (note_valid) begin
                            state <= ATTACK;
                            tw    <= note_tw;
                        end else begin
                            env <= env_dn;
                            if (env_dn == 8'd0) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign env_out         = env;
    assign active_out      = (state != IDLE);
    assign aud_sd          = (state != IDLE);
    assign sample_tick_out = tick;

endmodule

// File: tb/tb_note_synth_pwm.sv
// tb_note_synth_pwm: directed stimulus with a tick-level model of the
// envelope, phase and PWM; outputs compared on every falling edge.
module tb_note_synth_pwm;

    localparam int DIV = 16;

    localparam int M_IDLE = 0;
    localparam int M_ATK  = 1;
    localparam int M_SUS  = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [6:0] note = 7'd0;
    logic       aud_pwm;
    logic       aud_sd;
    logic       active;
    logic [7:0] env;
    logic       sample_tick;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    int tw_tab [7] = '{89895, 100901, 113260, 119994,
                       134690, 151183, 169696};

    int m_n = 0;
    int m_mode = M_IDLE;
    int m_env = 0;
    int m_phase = 0;
    int m_tw = 0;
    int m_level = 0;
    int m_pwm = 0;

    always #5 clk = ~clk;

    note_synth_pwm #(.SAMPLE_DIV(DIV)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (en),
        .note_in         (note),
        .aud_pwm         (aud_pwm),
        .aud_sd          (aud_sd),
        .active_out      (active),
        .env_out         (env),
        .sample_tick_out (sample_tick)
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, got, want, $time);
        end
    endtask

    function automatic int pick(input logic e, input logic [6:0] nv);
        int r = -1;
        if (e) begin
            for (int i = 0; i < 7; i++) begin
                if (nv[i]) r = i;
            end
        end
        return r;
    endfunction

    function automatic int wave(input int ph);
        int p = (ph / 65536) % 256;
        if (p < 128) return 2 * p;
        return 255 - 2 * (p - 128);
    endfunction

    task automatic model_tick();
        int nt = pick(en, note);
        if (m_mode != M_IDLE) m_phase = (m_phase + m_tw) % (1 << 24);
        case (m_mode)
            M_IDLE: begin
                if (nt >= 0) begin
                    m_mode = M_ATK;
                    m_phase = 0;
                    m_tw = tw_tab[nt];
                end
            end
            M_ATK: begin
                if (nt < 0) begin
                    m_mode = M_REL;
                end else begin
                    m_tw = tw_tab[nt];
                    m_env = (m_env + 8 > 255) ? 255 : m_env + 8;
                    if (m_env == 255) m_mode = M_SUS;
                end
            end
            M_SUS: begin
                if (nt < 0) begin
                    m_mode = M_REL;
                    m_env = m_env - 4;
                end else begin
                    m_tw = tw_tab[nt];
                end
            end
            default: begin
                if (nt >= 0) begin
                    m_mode = M_ATK;
                    m_tw = tw_tab[nt];
                end else begin
                    m_env = (m_env < 4) ? 0 : m_env - 4;
                    if (m_env == 0) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    // PWM uses the old level, level uses the old phase/env, then the
    // tick update: a three-clock path from tick to aud_pwm.
    always @(posedge clk) begin
        if (rst) begin
            m_n = 0;
            m_mode = M_IDLE;
            m_env = 0;
            m_phase = 0;
            m_tw = 0;
            m_level = 0;
            m_pwm = 0;
        end else begin
            m_pwm = ((m_n % 256) < m_level) ? 1 : 0;
            m_level = (wave(m_phase) * m_env) / 256;
            if (m_n % DIV == DIV - 1) model_tick();
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("env_out", int'(env), m_env);
            check("active_out", int'(active), int'(m_mode != M_IDLE));
            check("aud_sd", int'(aud_sd), int'(m_mode != M_IDLE));
            check("sample_tick", int'(sample_tick),
                  int'(m_n % DIV == DIV - 1));
            check("aud_pwm", int'(aud_pwm), m_pwm);
        end
    end

    task automatic ticks(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        note = 7'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;

        // Idle with no note
        ticks(10);
        check("idle_env", int'(env), 0);
        check("idle_active", int'(active), 0);
        check("idle_sd", int'(aud_sd), 0);
        check("idle_pwm", int'(aud_pwm), 0);

        // A4 attack to sustain
        note = 7'b0100000;
        ticks(1);
        check("start_env", int'(env), 0);
        check("start_active", int'(active), 1);
        ticks(1);
        check("attack_first", int'(env), 8);
        ticks(30);
        check("attack_248", int'(env), 248);
        ticks(1);
        check("attack_sat", int'(env), 255);
        ticks(8);

        // Retune in sustain, walk the table
        note = 7'b0000001;
        ticks(6);
        check("sustain_env", int'(env), 255);
        note = 7'b0000010;
        ticks(3);
        note = 7'b0000100;
        ticks(3);
        note = 7'b0001000;
        ticks(3);
        note = 7'b0010000;
        ticks(3);

        // Release to idle
        note = 7'd0;
        ticks(1);
        check("release_first", int'(env), 251);
        ticks(62);
        check("release_3", int'(env), 3);
        check("release_active", int'(active), 1);
        ticks(1);
        check("release_end", int'(env), 0);
        check("release_idle", int'(active), 0);
        check("release_sd", int'(aud_sd), 0);

        // Attack, release, retrigger at 100 with two notes held
        note = 7'b0100000;
        ticks(14);
        check("atk_104", int'(env), 104);
        note = 7'd0;
        ticks(1);
        check("rel_hold", int'(env), 104);
        ticks(1);
        check("rel_100", int'(env), 100);
        note = 7'b1000001;
        ticks(1);
        check("retrig_hold", int'(env), 100);
        ticks(1);
        check("retrig_108", int'(env), 108);
        ticks(1);
        check("retrig_116", int'(env), 116);

        // Enable drop acts as release
        en = 1'b0;
        ticks(1);
        check("en_off_hold", int'(env), 116);
        ticks(1);
        check("en_off_112", int'(env), 112);
        en = 1'b1;
        ticks(2);
        check("en_on_120", int'(env), 120);

        // Reset mid-attack
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_env", int'(env), 0);
        check("rst_pwm", int'(aud_pwm), 0);
        check("rst_sd", int'(aud_sd), 0);
        check("rst_active", int'(active), 0);

        // Normal note after reset, then full release
        ticks(20);
        note = 7'd0;
        ticks(80);
        check("final_idle", int'(active), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
